// File: rtl/mips_mc_control.sv
// mips_mc_control
// Multi-cycle MIPS control FSM. Sequences fetch, decode, execute, memory
// and write-back for lw, sw, R-type, addi, beq, j and jal, stalling in
// memory states until mem_ready. Also counts retired instructions.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   opcode          IR[31:26], valid from DECODE onward
//   mem_ready       memory completes the current access this cycle
//   mem_read/write  memory strobes; i_or_d selects PC (0) / ALUOut (1)
//   ir_write        IR load; pc_write / pc_write_cond PC load controls
//   pc_source       00 ALU, 01 ALUOut, 10 jump target
//   alu_op          00 add, 01 sub, 10 funct
//   alu_src_a/b     ALU operand selects
//   reg_write       register file write enable
//   reg_dst         00 rt, 01 rd, 10 $31
//   mem_to_reg      00 ALUOut, 01 MDR, 10 PC
//   illegal_op      pulse on unsupported opcode in DECODE
//   instr_retired   pulse on final cycle of each instruction
//   instr_count     retired instruction count (wraps)
//   dbg_state       current state encoding
module mips_mc_control #(
  parameter int unsigned COUNT_W = 32,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic [1:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal_op,
  output logic               instr_retired,
  output logic [COUNT_W-1:0] instr_count,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [STATE_W-1:0] {
    RESET_S, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP
  } state_t;

  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic               w_retire;
  logic               w_legal;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, OP_JAL: w_legal = 1'b1;
      default:                                               w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_S;
      r_count <= '0;
    end else begin
      if (w_retire) r_count <= r_count + COUNT_W'(1);
      case (r_state)
        RESET_S:   r_state <= FETCH;
        FETCH:     if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:      r_state <= EXEC_R;
            OP_LW, OP_SW:  r_state <= MEM_ADDR;
            OP_ADDI:       r_state <= EXEC_I;
            OP_BEQ:        r_state <= BRANCH;
            OP_J, OP_JAL:  r_state <= JUMP;
            default:       r_state <= FETCH;
          endcase
        end
        MEM_ADDR:  r_state <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ:  if (mem_ready) r_state <= MEM_WB;
        MEM_WB:    r_state <= FETCH;
        MEM_WRITE: if (mem_ready) r_state <= FETCH;
        EXEC_R:    r_state <= R_WB;
        R_WB:      r_state <= FETCH;
        EXEC_I:    r_state <= I_WB;
        I_WB:      r_state <= FETCH;
        BRANCH:    r_state <= FETCH;
        JUMP:      r_state <= FETCH;
        default:   r_state <= FETCH;
      endcase
    end
  end

  // Moore decode of r_state; FETCH and MEM_WRITE additionally qualify on
  // mem_ready, DECODE and JUMP on opcode. rst forces every strobe low so
  // no architectural write can happen in a reset cycle.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    illegal_op    = 1'b0;
    w_retire      = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !w_legal;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          w_retire   = 1'b1;
        end
        MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          w_retire  = mem_ready;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          w_retire  = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        I_WB: begin
          reg_write = 1'b1;
          w_retire  = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          w_retire      = 1'b1;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          w_retire  = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_retired = w_retire;
  assign instr_count   = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control
// Directed bench for mips_mc_control: walks each instruction class cycle
// by cycle with hand-written expected state/control values, exercises
// memory stalls, illegal opcode, counter wrap (narrow counter) and reset
// in the middle of write-back.
module tb_mips_mc_control;

  localparam int unsigned CW = 4;
  localparam int unsigned SW = 4;

  localparam logic [SW-1:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                            S_MADDR = 4'd3,  S_MREAD = 4'd4,  S_MWB    = 4'd5,
                            S_MWRITE = 4'd6, S_EXECR = 4'd7,  S_RWB    = 4'd8,
                            S_EXECI = 4'd9,  S_IWB   = 4'd10, S_BRANCH = 4'd11,
                            S_JUMP  = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_BAD = 6'b111111;

  typedef struct packed {
    logic       mr, mw, iord, irw, pcw, pcwc;
    logic [1:0] pcs, aop;
    logic       asa;
    logic [1:0] asb;
    logic       rw;
    logic [1:0] rdst, m2r;
    logic       ill, ret;
  } ctrl_t;

  localparam ctrl_t C_ZERO  = '0;
  localparam ctrl_t C_FETCH = '{mr:1'b1, irw:1'b1, pcw:1'b1, asb:2'b01, default:'0};
  localparam ctrl_t C_FWAIT = '{mr:1'b1, asb:2'b01, default:'0};
  localparam ctrl_t C_DEC   = '{asb:2'b11, default:'0};
  localparam ctrl_t C_ILL   = '{asb:2'b11, ill:1'b1, default:'0};
  localparam ctrl_t C_MADDR = '{asa:1'b1, asb:2'b10, default:'0};
  localparam ctrl_t C_MREAD = '{mr:1'b1, iord:1'b1, default:'0};
  localparam ctrl_t C_MWB   = '{rw:1'b1, m2r:2'b01, ret:1'b1, default:'0};
  localparam ctrl_t C_MWW   = '{mw:1'b1, iord:1'b1, default:'0};
  localparam ctrl_t C_MWR   = '{mw:1'b1, iord:1'b1, ret:1'b1, default:'0};
  localparam ctrl_t C_EXECR = '{asa:1'b1, aop:2'b10, default:'0};
  localparam ctrl_t C_RWB   = '{rw:1'b1, rdst:2'b01, ret:1'b1, default:'0};
  localparam ctrl_t C_EXECI = '{asa:1'b1, asb:2'b10, default:'0};
  localparam ctrl_t C_IWB   = '{rw:1'b1, ret:1'b1, default:'0};
  localparam ctrl_t C_BR    = '{asa:1'b1, aop:2'b01, pcwc:1'b1, pcs:2'b01, ret:1'b1, default:'0};
  localparam ctrl_t C_J     = '{pcw:1'b1, pcs:2'b10, ret:1'b1, default:'0};
  localparam ctrl_t C_JAL   = '{pcw:1'b1, pcs:2'b10, rw:1'b1, rdst:2'b10, m2r:2'b10, ret:1'b1, default:'0};

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_source, alu_op, alu_src_b, reg_dst, mem_to_reg;
  logic          alu_src_a, reg_write, illegal_op, instr_retired;
  logic [CW-1:0] instr_count;
  logic [SW-1:0] dbg_state;
  ctrl_t         obs;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mips_mc_control #(.COUNT_W(CW), .STATE_W(SW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .instr_retired(instr_retired), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                mem_to_reg, illegal_op, instr_retired};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock cycle: apply inputs, check state and controls mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(input logic [5:0] op, input logic rdy, input string tag,
                     input logic [SW-1:0] st, input ctrl_t c);
    opcode    = op;
    mem_ready = rdy;
    #1;
    chk({tag, ".state"}, 32'(dbg_state), 32'(st));
    chk({tag, ".ctrl"},  32'(obs),       32'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic beq_instr(input string tag);
    cyc(OP_BEQ, 1'b1, {tag, "_f"}, S_FETCH,  C_FETCH);
    cyc(OP_BEQ, 1'b1, {tag, "_d"}, S_DECODE, C_DEC);
    cyc(OP_BEQ, 1'b1, {tag, "_b"}, S_BRANCH, C_BR);
  endtask

  initial begin
    rst = 1'b1; opcode = OP_JAL; mem_ready = 1'b1;
    @(posedge clk); #1;
    // Reset asserted: all strobes forced low regardless of inputs.
    cyc(OP_JAL, 1'b1, "rst_hold", S_RESET, C_ZERO);
    chk("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b0;

    // R-type
    cyc(OP_R, 1'b1, "r_rst",   S_RESET, C_ZERO);
    cyc(OP_R, 1'b1, "r_fetch", S_FETCH, C_FETCH);
    cyc(OP_R, 1'b1, "r_dec",   S_DECODE, C_DEC);
    cyc(OP_R, 1'b1, "r_exec",  S_EXECR, C_EXECR);
    cyc(OP_R, 1'b1, "r_wb",    S_RWB, C_RWB);
    chk("cnt_after_r", 32'(instr_count), 32'd1);

    // lw with two wait cycles in MEM_READ (7 cycles)
    cyc(OP_LW, 1'b1, "lw_fetch", S_FETCH, C_FETCH);
    cyc(OP_LW, 1'b1, "lw_dec",   S_DECODE, C_DEC);
    cyc(OP_LW, 1'b1, "lw_addr",  S_MADDR, C_MADDR);
    cyc(OP_LW, 1'b0, "lw_rd0",   S_MREAD, C_MREAD);
    cyc(OP_LW, 1'b0, "lw_rd1",   S_MREAD, C_MREAD);
    cyc(OP_LW, 1'b1, "lw_rd2",   S_MREAD, C_MREAD);
    cyc(OP_LW, 1'b1, "lw_wb",    S_MWB, C_MWB);
    chk("cnt_after_lw", 32'(instr_count), 32'd2);

    // sw with one wait cycle
    cyc(OP_SW, 1'b1, "sw_fetch", S_FETCH, C_FETCH);
    cyc(OP_SW, 1'b1, "sw_dec",   S_DECODE, C_DEC);
    cyc(OP_SW, 1'b1, "sw_addr",  S_MADDR, C_MADDR);
    cyc(OP_SW, 1'b0, "sw_wait",  S_MWRITE, C_MWW);
    cyc(OP_SW, 1'b1, "sw_done",  S_MWRITE, C_MWR);
    chk("cnt_after_sw", 32'(instr_count), 32'd3);

    // beq with a fetch stall
    cyc(OP_BEQ, 1'b0, "beq_fwait", S_FETCH, C_FWAIT);
    beq_instr("beq");
    chk("cnt_after_beq", 32'(instr_count), 32'd4);

    // addi
    cyc(OP_ADDI, 1'b1, "addi_fetch", S_FETCH, C_FETCH);
    cyc(OP_ADDI, 1'b1, "addi_dec",   S_DECODE, C_DEC);
    cyc(OP_ADDI, 1'b1, "addi_exec",  S_EXECI, C_EXECI);
    cyc(OP_ADDI, 1'b1, "addi_wb",    S_IWB, C_IWB);
    chk("cnt_after_addi", 32'(instr_count), 32'd5);

    // j and jal
    cyc(OP_J,   1'b1, "j_fetch",   S_FETCH, C_FETCH);
    cyc(OP_J,   1'b1, "j_dec",     S_DECODE, C_DEC);
    cyc(OP_J,   1'b1, "j_jump",    S_JUMP, C_J);
    cyc(OP_JAL, 1'b1, "jal_fetch", S_FETCH, C_FETCH);
    cyc(OP_JAL, 1'b1, "jal_dec",   S_DECODE, C_DEC);
    cyc(OP_JAL, 1'b1, "jal_jump",  S_JUMP, C_JAL);
    chk("cnt_after_jal", 32'(instr_count), 32'd7);

    // Illegal opcode: pulse in DECODE, back to FETCH, not retired
    cyc(OP_BAD, 1'b1, "ill_fetch", S_FETCH, C_FETCH);
    cyc(OP_BAD, 1'b1, "ill_dec",   S_DECODE, C_ILL);
    chk("cnt_after_ill", 32'(instr_count), 32'd7);

    // Eight beqs bring the 4-bit counter to all-ones, one more wraps it
    for (int i = 0; i < 8; i++) beq_instr("wbeq");
    chk("cnt_allones", 32'(instr_count), 32'd15);
    beq_instr("wrap");
    chk("cnt_wrap", 32'(instr_count), 32'd0);

    // Reset asserted in MEM_WB of a lw
    cyc(OP_ADDI, 1'b1, "pre_fetch", S_FETCH, C_FETCH);
    cyc(OP_ADDI, 1'b1, "pre_dec",   S_DECODE, C_DEC);
    cyc(OP_ADDI, 1'b1, "pre_exec",  S_EXECI, C_EXECI);
    cyc(OP_ADDI, 1'b1, "pre_wb",    S_IWB, C_IWB);
    chk("cnt_pre_rst", 32'(instr_count), 32'd1);
    cyc(OP_LW, 1'b1, "rlw_fetch", S_FETCH, C_FETCH);
    cyc(OP_LW, 1'b1, "rlw_dec",   S_DECODE, C_DEC);
    cyc(OP_LW, 1'b1, "rlw_addr",  S_MADDR, C_MADDR);
    cyc(OP_LW, 1'b1, "rlw_rd",    S_MREAD, C_MREAD);
    rst = 1'b1;
    cyc(OP_LW, 1'b1, "rlw_wb_rst", S_MWB, C_ZERO);
    rst = 1'b0;
    chk("cnt_post_rst", 32'(instr_count), 32'd0);
    cyc(OP_LW, 1'b1, "post_rst",   S_RESET, C_ZERO);
    cyc(OP_LW, 1'b1, "post_fetch", S_FETCH, C_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
